// File: rtl/mem_pkg.sv
// Shared encodings for the RV32I memory-access stage: opcodes, load/store
// funct3 values, the access FSM states and the timeout counter width.
package mem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int TMO_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_SB, F3_SH, F3_SW: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/half lane from the read word
// and applies sign or zero extension according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  a_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension of the returned word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data_o = 32'h0000_0000;
        case (a_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (a_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
            F3_LH:   data_o = {{16{half_s[15]}}, half_s};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'h000000, byte_s};
            F3_LHU:  data_o = {16'h0000, half_s};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/memory_ctl.sv
// RV32I memory-access stage: captures execute results, runs the dmem req/ack
// handshake with timeout, and presents one registered result per instruction.
// Optional misaligned-access trap is enabled by MEM_CTL_MISALIGN_TRAP_EN.
module memory_ctl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] data_b_exe,
    input  logic [31:0] pc_exe,
    input  logic [31:0] instr_exe,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_instr,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [TMO_W-1:0]   cnt_q;
    logic [2:0]         f3_q;
    logic [1:0]         a_q;
    logic [31:0]        pc_q;
    logic [31:0]        instr_q;
    logic               req_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               wb_valid_q;
    logic [31:0]        wb_data_q;
    logic [31:0]        wb_pc_q;
    logic [31:0]        wb_instr_q;
    logic               misalign_q;
    logic               bus_err_q;

    logic [6:0]         opcode_s;
    logic [2:0]         f3_s;
    logic [1:0]         a_s;
    logic               is_mem_s;
    logic               is_store_s;
    logic               legal_s;
    logic               misalign_s;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;
    logic [31:0]        addr_d;
    logic [31:0]        ld_data_s;

    // Decode of the execute-stage instruction and store lane generation.
    always_comb begin
        opcode_s   = instr_exe[6:0];
        f3_s       = instr_exe[14:12];
        a_s        = alu_result[1:0];
        is_store_s = (opcode_s == OPC_STORE);
        is_mem_s   = (opcode_s == OPC_LOAD) || is_store_s;
        legal_s    = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = 32'h0000_0000;
        misalign_s = 1'b0;
        addr_d     = {alu_result[31:2], 2'b00};
        if (is_store_s) begin
            legal_s = store_f3_legal(f3_s);
            case (f3_s)
                F3_SB: begin
                    be_d    = 4'b0001 << a_s;
                    wdata_d = {4{data_b_exe[7:0]}};
                end
                F3_SH: begin
                    be_d    = a_s[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{data_b_exe[15:0]}};
                end
                F3_SW: begin
                    be_d    = 4'b1111;
                    wdata_d = data_b_exe;
                end
                default: begin
                    be_d    = 4'b0000;
                    wdata_d = 32'h0000_0000;
                end
            endcase
        end else begin
            legal_s = load_f3_legal(f3_s);
        end
`ifdef MEM_CTL_MISALIGN_TRAP_EN
        // Halves need a[0] clear (LH/LHU/SH share funct3 low bits); words need a == 0.
        case (f3_s)
            3'b001, 3'b101: misalign_s = is_mem_s && a_s[0];
            3'b010:         misalign_s = is_mem_s && (a_s != 2'b00);
            default:        misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .funct3_i (f3_q),
        .a_i      (a_q),
        .data_o   (ld_data_s)
    );

    // Access FSM with registered bus and writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            f3_q       <= 3'b000;
            a_q        <= 2'b00;
            pc_q       <= 32'h0000_0000;
            instr_q    <= 32'h0000_0000;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'h0000_0000;
            wb_pc_q    <= 32'h0000_0000;
            wb_instr_q <= 32'h0000_0000;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!exe_valid) begin
                        wb_valid_q <= 1'b0;
                    end else if (is_mem_s && legal_s && !misalign_s) begin
                        req_q      <= 1'b1;
                        we_q       <= is_store_s;
                        addr_q     <= addr_d;
                        be_q       <= be_d;
                        wdata_q    <= wdata_d;
                        f3_q       <= f3_s;
                        a_q        <= a_s;
                        pc_q       <= pc_exe;
                        instr_q    <= instr_exe;
                        cnt_q      <= '0;
                        wb_valid_q <= 1'b0;
                        state_q    <= BUSY;
                    end else if (is_mem_s && legal_s) begin
                        misalign_q <= 1'b1;
                        wb_valid_q <= 1'b0;
                    end else begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= is_mem_s ? 32'h0000_0000 : alu_result;
                        wb_pc_q    <= pc_exe;
                        wb_instr_q <= instr_exe;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        req_q      <= 1'b0;
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= we_q ? 32'h0000_0000 : ld_data_s;
                        wb_pc_q    <= pc_q;
                        wb_instr_q <= instr_q;
                    end else if (cnt_q == TMO_LAST) begin
                        req_q      <= 1'b0;
                        bus_err_q  <= 1'b1;
                        wb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q      <= cnt_q + 8'd1;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    req_q      <= 1'b0;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_mem  = (state_q == BUSY);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_pc      = wb_pc_q;
    assign wb_instr   = wb_instr_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_memory_ctl.sv
// Directed self-checking bench for memory_ctl (TIMEOUT = 4).
module tb_memory_ctl;

    logic        clk;
    logic        rst;
    logic        exe_valid;
    logic [31:0] alu_result;
    logic [31:0] data_b_exe;
    logic [31:0] pc_exe;
    logic [31:0] instr_exe;
    logic        stall_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic [31:0] wb_instr;
    logic        misalign;
    logic        bus_err;

    int n_chk;
    int n_pass;

    memory_ctl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .exe_valid  (exe_valid),
        .alu_result (alu_result),
        .data_b_exe (data_b_exe),
        .pc_exe     (pc_exe),
        .instr_exe  (instr_exe),
        .stall_mem  (stall_mem),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_pc      (wb_pc),
        .wb_instr   (wb_instr),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_i(input logic [2:0] f3, input logic [6:0] opc);
        return {17'h00000, f3, 5'd1, opc};
    endfunction

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] b, input logic [31:0] pc);
        exe_valid  = v;
        instr_exe  = ins;
        alu_result = alu;
        data_b_exe = b;
        pc_exe     = pc;
    endtask

    // Captures one access, acks in cycle k, then checks the held ADD is taken next.
    task automatic mem_access(input string tag, input logic [31:0] ins, input logic [31:0] alu,
                              input logic [31:0] b, input logic [31:0] pc, input int k,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic exp_we,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        drive(1'b1, ins, alu, b, pc);
        tick();
        check_val({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
        check_val({tag, ".addr"}, dmem_addr, exp_addr);
        check_val({tag, ".be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        check_val({tag, ".we"}, {31'd0, dmem_we}, {31'd0, exp_we});
        if (exp_we) check_val({tag, ".wdata"}, dmem_wdata, exp_wdata);
        check_val({tag, ".stall0"}, {31'd0, stall_mem}, 32'd1);
        drive(1'b1, mk_i(3'b000, OP_ALU), 32'h0000_0AAA, 32'h0, pc + 32'd4);
        for (int i = 1; i < k; i++) begin
            tick();
            check_val({tag, ".stall"}, {31'd0, stall_mem}, 32'd1);
            check_val({tag, ".wbv_busy"}, {31'd0, wb_valid}, 32'd0);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack   = 1'b0;
        check_val({tag, ".wbv"}, {31'd0, wb_valid}, 32'd1);
        check_val({tag, ".wbdata"}, wb_data, exp_wb);
        check_val({tag, ".wbpc"}, wb_pc, pc);
        check_val({tag, ".wbinstr"}, wb_instr, ins);
        check_val({tag, ".req_done"}, {31'd0, dmem_req}, 32'd0);
        check_val({tag, ".stall_done"}, {31'd0, stall_mem}, 32'd0);
        check_val({tag, ".buserr"}, {31'd0, bus_err}, 32'd0);
        tick();
        check_val({tag, ".next_v"}, {31'd0, wb_valid}, 32'd1);
        check_val({tag, ".next_data"}, wb_data, 32'h0000_0AAA);
        check_val({tag, ".next_pc"}, wb_pc, pc + 32'd4);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check_val({tag, ".bubble"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        check_val("rst.req", {31'd0, dmem_req}, 32'd0);
        check_val("rst.stall", {31'd0, stall_mem}, 32'd0);
        check_val("rst.wbv", {31'd0, wb_valid}, 32'd0);
        check_val("rst.wbdata", wb_data, 32'd0);
        check_val("rst.addr", dmem_addr, 32'd0);
        check_val("rst.flags", {30'd0, misalign, bus_err}, 32'd0);
        rst = 1'b0;
        tick();

        // ADD, LW (3-cycle ack), ADD
        drive(1'b1, mk_i(3'b000, OP_ALU), 32'h0000_1234, 32'h0, 32'h0000_0040);
        tick();
        check_val("add.v", {31'd0, wb_valid}, 32'd1);
        check_val("add.data", wb_data, 32'h0000_1234);
        check_val("add.pc", wb_pc, 32'h0000_0040);
        mem_access("lw", mk_i(3'b010, OP_LD), 32'h0000_0100, 32'h0, 32'h0000_0044, 3,
                   32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);
        mem_access("lw_k1", mk_i(3'b010, OP_LD), 32'h0000_0104, 32'h0, 32'h0000_0050, 1,
                   32'h1357_9BDF, 32'h0000_0104, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF);
        mem_access("lb", mk_i(3'b000, OP_LD), 32'h0000_0203, 32'h0, 32'h0000_0060, 1,
                   32'h80AA_BBCC, 32'h0000_0200, 4'b1111, 1'b0, 32'h0, 32'hFFFF_FF80);
        mem_access("lbu", mk_i(3'b100, OP_LD), 32'h0000_0203, 32'h0, 32'h0000_0070, 1,
                   32'h80AA_BBCC, 32'h0000_0200, 4'b1111, 1'b0, 32'h0, 32'h0000_0080);
        mem_access("lh", mk_i(3'b001, OP_LD), 32'h0000_0202, 32'h0, 32'h0000_0080, 2,
                   32'h80AA_BBCC, 32'h0000_0200, 4'b1111, 1'b0, 32'h0, 32'hFFFF_80AA);
        mem_access("lhu", mk_i(3'b101, OP_LD), 32'h0000_0200, 32'h0, 32'h0000_0090, 1,
                   32'h80AA_BBCC, 32'h0000_0200, 4'b1111, 1'b0, 32'h0, 32'h0000_BBCC);
        mem_access("sh", mk_i(3'b001, OP_ST), 32'h0000_0102, 32'h1234_ABCD, 32'h0000_00A0, 1,
                   32'hFFFF_FFFF, 32'h0000_0100, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0);
        mem_access("sb", mk_i(3'b000, OP_ST), 32'h0000_0101, 32'h0000_005A, 32'h0000_00B0, 1,
                   32'hFFFF_FFFF, 32'h0000_0100, 4'b0010, 1'b1, 32'h5A5A_5A5A, 32'h0);
        mem_access("sw", mk_i(3'b010, OP_ST), 32'h0000_0108, 32'hCAFE_F00D, 32'h0000_00C0, 2,
                   32'hFFFF_FFFF, 32'h0000_0108, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0);
        // ack on the timeout edge completes normally
        mem_access("ack_at_tmo", mk_i(3'b010, OP_LD), 32'h0000_0300, 32'h0, 32'h0000_00D0, 4,
                   32'h0BAD_F00D, 32'h0000_0300, 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D);

        // timeout: no ack for 4 BUSY cycles
        drive(1'b1, mk_i(3'b010, OP_LD), 32'h0000_0300, 32'h0, 32'h0000_00E0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_val("tmo.wait_err", {31'd0, bus_err}, 32'd0);
            check_val("tmo.wait_req", {31'd0, dmem_req}, 32'd1);
        end
        tick();
        check_val("tmo.err", {31'd0, bus_err}, 32'd1);
        check_val("tmo.req", {31'd0, dmem_req}, 32'd0);
        check_val("tmo.wbv", {31'd0, wb_valid}, 32'd0);
        check_val("tmo.stall", {31'd0, stall_mem}, 32'd0);
        tick();
        check_val("tmo.err_pulse", {31'd0, bus_err}, 32'd0);

        // illegal load funct3: immediate result of 0
        drive(1'b1, mk_i(3'b011, OP_LD), 32'h0000_0400, 32'h0, 32'h0000_00F0);
        tick();
        check_val("ill.v", {31'd0, wb_valid}, 32'd1);
        check_val("ill.data", wb_data, 32'h0);
        check_val("ill.req", {31'd0, dmem_req}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        // stray ack while idle
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_val("stray.wbv", {31'd0, wb_valid}, 32'd0);
        check_val("stray.stall", {31'd0, stall_mem}, 32'd0);

`ifdef MEM_CTL_MISALIGN_TRAP_EN
        drive(1'b1, mk_i(3'b010, OP_LD), 32'h0000_0101, 32'h0, 32'h0000_0110);
        tick();
        check_val("mis.pulse", {31'd0, misalign}, 32'd1);
        check_val("mis.req", {31'd0, dmem_req}, 32'd0);
        check_val("mis.wbv", {31'd0, wb_valid}, 32'd0);
        check_val("mis.stall", {31'd0, stall_mem}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check_val("mis.end", {31'd0, misalign}, 32'd0);
`else
        mem_access("lw_unal", mk_i(3'b010, OP_LD), 32'h0000_0101, 32'h0, 32'h0000_0110, 1,
                   32'h7654_3210, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'h7654_3210);
        check_val("lw_unal.mis", {31'd0, misalign}, 32'd0);
`endif

        // reset mid-access drops the request at once
        drive(1'b1, mk_i(3'b010, OP_LD), 32'h0000_0500, 32'h0, 32'h0000_0120);
        tick();
        check_val("rstb.req_pre", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rstb.req", {31'd0, dmem_req}, 32'd0);
        check_val("rstb.stall", {31'd0, stall_mem}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        check_val("rstb.idle", {31'd0, stall_mem}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
